// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: matrix drive/sense, clear request and accepted-key outputs.
// master = keypad/host side, slave = scanner.
interface keypad_if;
  logic [3:0]  rows;
  logic        clear;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  modport master (
    output rows, clear,
    input  cols, key_code, key_valid, key_held, digits
  );

  modport slave (
    input  rows, clear,
    output cols, key_code, key_valid, key_held, digits
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: one column low per tick, per-scan single-key decode,
// scan-level debounce of press and release, and a 4-digit entry shift register.
module keypad_scanner #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  keypad_if.slave  kp_io
);

  localparam int unsigned Tp   = CLK_FREQ / SCAN_HZ;
  localparam int unsigned DivW = (Tp > 1) ? $clog2(Tp) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivMax = DivW'(Tp - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDebounce = 2'd1;
  localparam logic [1:0] StHeld     = 2'd2;
  localparam logic [1:0] StRelease  = 2'd3;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      acc_n_q, acc_n_d;    // switches seen this scan, saturating at 2
  logic [3:0]      acc_code_q, acc_code_d;
  logic [1:0]      state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic [15:0]     digits_q, digits_d;

  logic            tick, scan_end, scan_key, accept;
  logic [3:0]      pressed, cur_code, scan_code;
  logic [2:0]      n_col, tot;
  logic [1:0]      row_idx;
  logic [CntW-1:0] cnt_inc;

  assign tick     = (div_q == DivMax);
  assign scan_end = tick && (col_q == 2'd3);
  assign pressed  = ~kp_io.rows;
  assign n_col    = {2'b0, pressed[0]} + {2'b0, pressed[1]} +
                    {2'b0, pressed[2]} + {2'b0, pressed[3]};
  assign tot      = {1'b0, acc_n_q} + n_col;
  assign cur_code = key_map(row_idx, col_q);
  assign scan_key  = (tot == 3'd1);
  assign scan_code = (acc_n_q == 2'd1) ? acc_code_q : cur_code;
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    row_idx = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r]) row_idx = 2'(r);
    end
  end

  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    col_d      = tick ? col_q + 2'd1 : col_q;
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (scan_end) begin
      acc_n_d    = 2'd0;
      acc_code_d = 4'h0;
    end else if (tick) begin
      acc_n_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
      if (acc_n_q == 2'd0 && n_col == 3'd1) acc_code_d = cur_code;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (scan_end) begin
      case (state_q)
        StIdle: begin
          if (scan_key) begin
            cand_d  = scan_code;
            cnt_d   = CntOne;
            state_d = StDebounce;
          end
        end
        StDebounce: begin
          if (!scan_key) begin
            state_d = StIdle;
          end else if (scan_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntMax) begin
              state_d = StHeld;
              accept  = 1'b1;
            end
          end else begin
            cand_d = scan_code;
            cnt_d  = CntOne;
          end
        end
        StHeld: begin
          // Roll-over to another key keeps us here without a new pulse.
          if (!scan_key) begin
            cnt_d   = CntOne;
            state_d = StRelease;
          end
        end
        default: begin
          if (scan_key) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntMax) state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? cand_q : key_code_q;
    digits_d    = accept ? {digits_q[11:0], cand_q} : digits_q;
    if (kp_io.clear) digits_d = accept ? {12'h000, cand_q} : 16'h0000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q       <= '0;
      col_q       <= 2'd0;
      acc_n_q     <= 2'd0;
      acc_code_q  <= 4'h0;
      state_q     <= StIdle;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      digits_q    <= 16'h0000;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      digits_q    <= digits_d;
    end
  end

  assign kp_io.cols      = ~(4'b0001 << col_q);
  assign kp_io.key_code  = key_code_q;
  assign kp_io.key_valid = key_valid_q;
  assign kp_io.key_held  = (state_q == StHeld) || (state_q == StRelease);
  assign kp_io.digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated switch matrix, scan-history reference model
// checked every cycle, table-driven entry sequences and hand-written corner cases.
module tb_keypad_scanner;
  localparam int TP   = 10;
  localparam int DS   = 3;
  localparam int SCAN = 4 * TP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pmask = 16'h0;   // pressed switches, bit index = row*4 + col
  logic [3:0]  rows_drv;

  keypad_if kp ();

  keypad_scanner #(
    .CLK_FREQ       (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .kp_io  (kp)
  );

  always #5 clk = ~clk;

  // Matrix: a row reads low if any pressed switch on it sits in a driven-low column.
  always_comb begin
    rows_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pmask[r*4+c] && !kp.cols[c]) rows_drv[r] = 1'b0;
  end
  assign kp.rows = rows_drv;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  int          errors = 0, checks = 0;
  int          n, pulses, first_pulse;
  int          hist [$];          // last DS scan results, 16 = no single key
  bit          m_held;
  logic        m_valid;
  logic [3:0]  m_code;
  logic [15:0] m_digits;

  typedef struct {
    logic [15:0] mask;
    int          press;
    int          rel;
    int          exp_pulses;
    logic [15:0] exp_digits;
    logic [3:0]  exp_code;
  } vec_t;
  vec_t vecs [$];

  function automatic logic [15:0] mask_of(input logic [3:0] code);
    for (int i = 0; i < 16; i++) if (kmap[i] == code) return 16'(1) << i;
    return 16'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; hist.delete(); m_held = 0; m_valid = 0; m_code = 4'h0; m_digits = 16'h0;
  endtask

  // One clock: the model decides each scan from the set of keys held during it.
  task automatic step(input bit clr);
    int res, same;
    kp.clear = clr;
    @(posedge clk);
    #1;
    kp.clear = 1'b0;
    n++;
    m_valid = 1'b0;
    if (n % SCAN == 0) begin
      res = 16;
      if ($countones(pmask) == 1)
        for (int i = 0; i < 16; i++) if (pmask[i]) res = int'(kmap[i]);
      hist.push_back(res);
      if (hist.size() > DS) void'(hist.pop_front());
      same = (hist.size() == DS) ? 1 : 0;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
      if (same == 1 && !m_held && hist[0] != 16) begin
        m_valid = 1'b1; m_held = 1; m_code = 4'(hist[0]);
        m_digits = {m_digits[11:0], m_code};
      end else if (same == 1 && m_held && hist[0] == 16) begin
        m_held = 0;
      end
    end
    if (clr) m_digits = m_valid ? {12'h000, m_code} : 16'h0000;
    check("cycle", {kp.cols, kp.key_code, kp.key_valid, kp.key_held, kp.digits},
          {~(4'b0001 << ((n / TP) % 4)), m_code, m_valid, m_held, m_digits});
    if (kp.key_valid) begin
      pulses++;
      if (first_pulse < 0) first_pulse = n;
    end
  endtask

  task automatic run(input logic [15:0] mask, input int scans, input int clr_at);
    pmask = mask;
    for (int i = 0; i < scans * SCAN; i++) step(i == clr_at);
  endtask

  logic [3:0] cseq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    kp.clear = 1'b0;
    model_reset();
    #12;
    check("reset", {kp.cols, kp.key_code, kp.key_valid, kp.key_held, kp.digits},
          {4'b1110, 4'h0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk) rst_n = 1'b1;

    // Column rotation over the first scan.
    for (int i = 1; i <= SCAN; i++) begin
      step(1'b0);
      if (i == 9) check("cols_hold", 32'(kp.cols), 32'(4'b1110));
      if (i % TP == 0) check("cols_step", 32'(kp.cols), 32'(cseq[i / TP - 1]));
    end

    // '5' held 200 cycles from a scan boundary: pulse one cycle after 3rd scan end.
    pulses = 0; first_pulse = -1;
    run(mask_of(4'h5), 5, -1);
    check("k5_pulses", 32'(pulses), 32'd1);
    check("k5_latency", 32'(first_pulse), 32'(SCAN + DS * SCAN));
    check("k5_code", 32'(kp.key_code), 32'h5);
    check("k5_digits", 32'(kp.digits), 32'h0005);
    check("k5_held", 32'(kp.key_held), 32'd1);
    run(16'h0, DS, -1);
    check("k5_released", 32'(kp.key_held), 32'd0);

    vecs.push_back('{mask_of(4'hA), 2, 1, 0, 16'h0005, 4'h5});
    vecs.push_back('{mask_of(4'hA), 3, 3, 1, 16'h005A, 4'hA});
    vecs.push_back('{mask_of(4'h1), 3, 3, 1, 16'h05A1, 4'h1});
    vecs.push_back('{mask_of(4'h2), 3, 3, 1, 16'h5A12, 4'h2});
    vecs.push_back('{mask_of(4'h3), 3, 3, 1, 16'hA123, 4'h3});
    vecs.push_back('{mask_of(4'h4), 3, 3, 1, 16'h1234, 4'h4});
    vecs.push_back('{mask_of(4'hE), 3, 3, 1, 16'h234E, 4'hE});
    vecs.push_back('{mask_of(4'h1) | mask_of(4'h2), 5, 3, 0, 16'h234E, 4'hE});
    vecs.push_back('{mask_of(4'h1) | mask_of(4'h5), 4, 3, 0, 16'h234E, 4'hE});
    foreach (vecs[i]) begin
      pulses = 0;
      run(vecs[i].mask, vecs[i].press, -1);
      run(16'h0, vecs[i].rel, -1);
      check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
      check($sformatf("vec%0d_digits", i), 32'(kp.digits), 32'(vecs[i].exp_digits));
      check($sformatf("vec%0d_code", i), 32'(kp.key_code), 32'(vecs[i].exp_code));
    end

    run(16'h0, 1, 0);
    check("clear", 32'(kp.digits), 32'h0000);

    // Roll-over '0' -> 'D' without release: one pulse only.
    pulses = 0;
    run(mask_of(4'h0), 4, -1);
    run(mask_of(4'hD), 4, -1);
    check("roll_pulses", 32'(pulses), 32'd1);
    check("roll_code", 32'(kp.key_code), 32'h0);
    check("roll_held", 32'(kp.key_held), 32'd1);
    run(16'h0, DS, -1);

    // CLEAR on the accepting edge keeps only the new key.
    run(mask_of(4'h9), 2, -1);
    run(mask_of(4'h9), 1, SCAN - 1);
    check("clear_shift", 32'(kp.digits), 32'h0009);
    run(16'h0, DS, -1);

    // Reset during debounce of 'F' discards the candidate.
    run(mask_of(4'hF), 2, -1);
    rst_n = 1'b0;
    #1;
    check("mid_reset", {kp.cols, kp.key_code, kp.key_valid, kp.key_held, kp.digits},
          {4'b1110, 4'h0, 1'b0, 1'b0, 16'h0000});
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    run(mask_of(4'hF), 2, -1);
    check("f_fresh2", 32'(pulses), 32'd0);
    run(mask_of(4'hF), 1, -1);
    check("f_fresh3", 32'(pulses), 32'd1);
    check("f_digits", 32'(kp.digits), 32'h000F);
    run(16'h0, DS, -1);

    // Random scan-aligned press patterns against the model.
    for (int s = 0; s < 40; s++) begin
      int sel, scans, clr_at;
      logic [15:0] m;
      sel = $urandom_range(0, 19);
      if (sel < 9) m = 16'h0;
      else if (sel < 16) m = 16'(1) << $urandom_range(0, 15);
      else m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      scans  = $urandom_range(1, 5);
      clr_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, scans * SCAN - 1) : -1;
      run(m, scans, clr_at);
    end
    run(16'h0, DS, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix hex keypad: drives one column low at a time, samples active-low rows, debounces across full scans and emits one KEY_VALID pulse per debounced press. Entered digits are shifted into a 16-bit register, DIGITS, that feeds the four-digit seven-segment display HEX input. This makes it the input-side counterpart of the scanned display driver.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
SCAN_HZ, 1000, column step rate in Hz. Tick period TP = CLK_FREQ/SCAN_HZ cycles.
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or a release. Must be >= 2.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
ROWS  input  4  keypad rows, active low, externally pulled up; already synchronised upstream.
CLEAR  input  1  synchronous; zeroes DIGITS.
COLS  output  4  column drive, active low, exactly one bit low.
KEY_CODE  output  4  last accepted key code.
KEY_VALID  output  1  one-cycle pulse per accepted press.
KEY_HELD  output  1  high while an accepted key is held.
DIGITS  output  16  entry shift register; newest key in [3:0].

Behaviour:
- Reset (RST_N low, async): COLS=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0, DIGITS=0. State IDLE; tick counter, column index, debounce counter and scan accumulators all cleared. A reset mid-debounce discards the candidate.
- Tick: the divider counts 0..TP-1 and asserts tick on TP-1.
- Sampling on tick: sample ROWS for the current column c (driven for a full TP, so it has settled). Then advance c to (c+1) mod 4 and set COLS=~(4'b0001<<c).
- Full scan: ends on the tick that samples c=3.
- Key map, row r (ROWS bit r low), column c. Code = r0:{1,2,3,A}, r1:{4,5,6,B}, r2:{7,8,9,C}, r3:{0,F,E,D} for c=0..3.
- Scan result: exactly one switch low across the scan gives KEY(code). Zero switches, or two or more (ghosting/chord), give NONE. Accumulators clear at each scan end.
- FSM (evaluated at scan end only):
  - IDLE: on KEY(k), store cand=k, cnt=1, go to DEBOUNCE. On NONE, stay.
  - DEBOUNCE: on KEY(cand), cnt+1. When cnt reaches DEBOUNCE_SCANS: go to HELD, KEY_CODE=cand, pulse KEY_VALID, DIGITS={DIGITS[11:0],cand}. On KEY(other), cand=other, cnt=1. On NONE, go to IDLE.
  - HELD: KEY_HELD=1. On NONE, cnt=1 and go to RELEASE. On any KEY, stay; a roll-over to a different key produces no pulse.
  - RELEASE: KEY_HELD stays 1. On NONE, cnt+1; when cnt reaches DEBOUNCE_SCANS go to IDLE and drop KEY_HELD. On any KEY, return to HELD.
- Output timing: KEY_VALID and the KEY_CODE/DIGITS update are registered. They appear the cycle after the accepting scan-end tick, and KEY_VALID is high for exactly one CLK.
- Press latency: a press stable from a scan boundary is accepted at the DEBOUNCE_SCANS-th scan end, i.e. DEBOUNCE_SCANS*4*TP cycles later, +1.
- CLEAR: DIGITS=0 on the next edge. If CLEAR coincides with a DIGITS shift, the result is {12'h000,cand}.
- Width rules: DIGITS shift discards bits [15:12]. The divider counter is sized $clog2(TP). cnt saturates and never wraps.

Test Plan:
All cases use CLK_FREQ=1000, SCAN_HZ=100 (TP=10) and DEBOUNCE_SCANS=3.
- Reset -> COLS=1110, all other outputs 0. Over 40 cycles, COLS follows 1110,1101,1011,0111, changing every 10 cycles, then wraps to 1110.
- Hold key '5' (ROWS[1] low only while COLS=1101) for 200 cycles -> exactly one KEY_VALID, KEY_CODE=4'h5, DIGITS=16'h0005, KEY_HELD=1. Pulse arrives 1 cycle after the 3rd scan end containing the press.
- Press 'A' for 2 scans, release for 1 scan, press again for 3 scans -> the first attempt gives no pulse; one pulse follows the 3rd stable scan.
- Enter 1,2,3,4,E with release between each (>=3 NONE scans) -> five pulses, DIGITS=16'h234E. Then CLEAR for one cycle -> DIGITS=16'h0000.
- Hold '1' and '2' simultaneously -> no pulse. Hold '0', then roll over to 'D' without release -> one pulse only (code 0), KEY_HELD stays 1.
- Assert RST_N low during DEBOUNCE (after 2 scans of 'F') -> outputs reset immediately. After release, 'F' needs 3 fresh scans to pulse.
